// File: rtl/cordic_pkg.sv
// Shared CORDIC types and constants: coordinate-system encoding, iteration
// index width and the hyperbolic repeat-iteration set.
package cordic_pkg;

  typedef enum logic [1:0] {
    CIRC = 2'b00,
    LIN  = 2'b01,
    RSVD = 2'b10,
    HYP  = 2'b11
  } coord_sys_e;

  localparam int unsigned CORDIC_IDX_W = 6;
  localparam int unsigned HYP_REPEAT_N = 3;

  // Entry [0] is the first repeat taken in a hyperbolic run.
  localparam logic [HYP_REPEAT_N-1:0][CORDIC_IDX_W-1:0] HYP_REPEAT_IDX =
    {6'd40, 6'd13, 6'd4};

endpackage

// File: rtl/hyp_repeat_detect.sv
// Combinational match of an iteration index against the hyperbolic repeat set.
// en gates the match so the caller can disable repeats without dangling logic.
module hyp_repeat_detect
  import cordic_pkg::*;
(
  input  logic                    en,
  input  logic [CORDIC_IDX_W-1:0] idx,
  output logic                    hit
);

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < int'(HYP_REPEAT_N); i++) begin
      if (idx == HYP_REPEAT_IDX[i]) hit = 1'b1;
    end
    hit = hit & en;
  end

endmodule

// File: rtl/counter_mod.sv
// CORDIC iteration sequencer: emits the per-cycle iteration index and, in
// hyperbolic mode, repeats indices 4/13/40 once (COUNTER_MOD_HYP_REPEAT_EN).
module counter_mod
  import cordic_pkg::*;
#(
  parameter int unsigned ITER_LAST = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              coordinate_system_in,
  input  logic                    en,
  output logic [CORDIC_IDX_W-1:0] out
);

  localparam logic [CORDIC_IDX_W-1:0] LAST = CORDIC_IDX_W'(ITER_LAST);

  logic [CORDIC_IDX_W-1:0] q, q_d;
  logic [1:0]              r;
  logic                    del;
  logic                    h;
  logic                    rep_en;
  logic                    rep_hit;
  logic                    pending;
  logic                    sat;
  logic                    adv;

  assign h   = (coord_sys_e'(coordinate_system_in) == HYP);
  assign out = q + CORDIC_IDX_W'(h) - CORDIC_IDX_W'(r);

`ifdef COUNTER_MOD_HYP_REPEAT_EN
  assign rep_en = h;
`else
  assign rep_en = 1'b0;
`endif

  hyp_repeat_detect u_rep (
    .en  (rep_en),
    .idx (out),
    .hit (rep_hit)
  );

  assign pending = rep_hit & ~del;
  // >= rather than == keeps the block parked if a mode change lifts out past the end.
  assign sat     = (out >= LAST) & ~pending;
  assign adv     = en & ~sat;
  assign q_d     = adv ? q + 1'b1 : q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q <= '0;
    else      q <= q_d;
  end

`ifdef COUNTER_MOD_HYP_REPEAT_EN
  logic [1:0] r_d;
  logic       del_d;

  always_comb begin
    r_d   = r;
    del_d = del;
    if (adv) begin
      if (pending) begin
        r_d   = r + 2'd1;
        del_d = 1'b1;
      end else begin
        del_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r   <= '0;
      del <= 1'b0;
    end else begin
      r   <= r_d;
      del <= del_d;
    end
  end
`else
  assign r   = 2'd0;
  assign del = 1'b0;
`endif

endmodule

// File: tb/tb_counter_mod.sv
// Directed bench for counter_mod (ITER_LAST = 15); expectations follow the
// COUNTER_MOD_HYP_REPEAT_EN setting of the build.
module tb_counter_mod;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic       en;
  logic [5:0] out;

  int n_chk  = 0;
  int n_fail = 0;

  counter_mod #(.ITER_LAST(15)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .coordinate_system_in (mode),
    .en                   (en),
    .out                  (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_to(input logic [1:0] m);
    en   = 1'b0;
    mode = m;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

`ifdef COUNTER_MOD_HYP_REPEAT_EN
  localparam bit REP = 1'b1;
  int exp_hyp [8] = '{2, 3, 4, 4, 5, 6, 7, 8};
  int exp_del [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
`else
  localparam bit REP = 1'b0;
  int exp_hyp [8] = '{2, 3, 4, 5, 6, 7, 8, 9};
  int exp_del [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif

  initial begin
    int seen_del;
    int lin_exp [5];
    int k;

    // Hyperbolic start-up, rst low for 10 ns
    rst  = 1'b0;
    en   = 1'b0;
    mode = 2'b11;
    #10;
    check("rst_out_hyp", out, 1);
    check("rst_q", dut.q, 0);
    check("rst_r", dut.r, 0);
    check("rst_del", dut.del, 0);
    rst = 1'b1;
    en  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("hyp_out[%0d]", i), out, exp_hyp[i]);
      check($sformatf("hyp_del[%0d]", i), dut.del, exp_del[i]);
    end

    // Circular: 0..15 then hold
    reset_to(2'b00);
    check("circ_rst_out", out, 0);
    en = 1'b1;
    seen_del = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      check($sformatf("circ_out[%0d]", i), out, (i > 15) ? 15 : i);
      if (dut.del) seen_del = 1;
    end
    check("circ_q_final", dut.q, 15);
    check("circ_del_never", seen_del, 0);
    // Mode change re-evaluates out immediately
    mode = 2'b11;
    #1;
    check("mode_change_out", out, 16);

    // Hyperbolic run to saturation
    reset_to(2'b11);
    en = 1'b1;
    for (int i = 0; i < 22; i++) step();
    check("hsat_out", out, 15);
    check("hsat_q", dut.q, REP ? 16 : 14);
    check("hsat_r", dut.r, REP ? 2 : 0);
    check("hsat_del", dut.del, 0);
    step();
    check("hsat_hold_out", out, 15);
    check("hsat_hold_q", dut.q, REP ? 16 : 14);

    // Reserved encoding behaves as circular
    reset_to(2'b10);
    check("rsvd_rst_out", out, 0);
    en = 1'b1;
    step();
    check("rsvd_out1", out, 1);

    // Linear with en toggling
    reset_to(2'b01);
    check("lin_out0", out, 0);
    lin_exp = '{1, 1, 2, 2, 3};
    for (int i = 0; i < 5; i++) begin
      en = (i % 2 == 0);
      step();
      check($sformatf("lin_out[%0d]", i + 1), out, lin_exp[i]);
    end

    // Async reset mid-cycle at out = 7 in hyperbolic mode
    reset_to(2'b11);
    en = 1'b1;
    k  = 0;
    while (out != 7 && k < 20) begin
      step();
      k++;
    end
    check("arst_reach7", out, 7);
    check("arst_edges", k, REP ? 7 : 6);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out", out, 1);
    check("arst_del", dut.del, 0);
    check("arst_q", dut.q, 0);
    check("arst_r", dut.r, 0);
    step();
    check("arst_hold_out", out, 1);
    rst = 1'b1;
    en  = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
